// File: rtl/sw_debounce.sv
// Per-bit switch synchroniser and debouncer with one-cycle rise/fall pulses and a busy flag.
// Define SW_DEBOUNCE_STICKY_EN to build the latched-rise (sticky) flags cleared by clr.
module sw_debounce #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             busy,
   output logic [WIDTH-1:0] sticky
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [CNT_W-1:0] cnt     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] acc;
   logic             busy_nxt;

   // A bit is accepted on the edge its disagreement count reaches the terminal value;
   // any agreeing cycle drops the count straight back to zero.
   always_comb begin
      s        = sync_q[SYNC_STAGES-1];
      acc      = '0;
      busy_nxt = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (s[i] != sw_out[i]) begin
            if (cnt[i] == TERM) acc[i] = 1'b1;
            else                cnt_nxt[i] = cnt[i] + 1'b1;
         end
         busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int st = 0; st < SYNC_STAGES; st++) sync_q[st] <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
         sw_out <= '0;
         rise   <= '0;
         fall   <= '0;
         busy   <= 1'b0;
      end else begin
         sync_q[0] <= sw_raw;
         for (int st = 1; st < SYNC_STAGES; st++) sync_q[st] <= sync_q[st-1];
         for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
         sw_out <= sw_out ^ acc;
         rise   <= acc & s;
         fall   <= acc & ~s;
         busy   <= busy_nxt;
      end
   end

`ifdef SW_DEBOUNCE_STICKY_EN
   // Set takes priority over a clear landing on the same edge.
   always_ff @(posedge CLK) begin
      if (RST) sticky <= '0;
      else     sticky <= (sticky & ~clr) | (acc & s);
   end
`else
   logic unused_clr;
   assign unused_clr = ^clr;
   assign sticky     = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: a window-based reference model queues expected outputs per edge,
// a monitor pops and compares them one step after each rising edge.
module tb_sw_debounce;

   localparam int W    = 4;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic [W-1:0] sw_raw, clr;
   logic [W-1:0] sw_out, rise, fall, sticky;
   logic         busy;

   sw_debounce #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(20)) dut (
      .CLK(CLK), .RST(RST), .sw_raw(sw_raw), .clr(clr),
      .sw_out(sw_out), .rise(rise), .fall(fall), .busy(busy), .sticky(sticky)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [W-1:0] sw_out;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         busy;
      logic [W-1:0] sticky;
   } exp_t;

   exp_t exp_q [$];
   int   tests  = 0;
   int   failed = 0;
   int   edge_n = 0;

   // Reference model state: recent raw inputs and the levels the debouncer has seen.
   logic [W-1:0] raw_hist [$];
   logic [W-1:0] s_hist   [$];
   logic [W-1:0] out_m;
   logic [W-1:0] sticky_m;

   function automatic void model_reset();
      raw_hist.delete();
      for (int k = 0; k < SYNC; k++) raw_hist.push_back('0);
      s_hist.delete();
      out_m    = '0;
      sticky_m = '0;
   endfunction

   // Expected outputs after the coming edge, derived from "the last DEB seen levels all disagree".
   function automatic exp_t model_edge(input logic rst_v, input logic [W-1:0] raw_v, input logic [W-1:0] clr_v);
      exp_t         e;
      logic [W-1:0] s_now, new_out, rs;
      logic         all_diff;
      if (rst_v) begin
         model_reset();
         e = '0;
         return e;
      end
      raw_hist.push_back(raw_v);
      s_now = raw_hist[raw_hist.size()-1-SYNC];
      if (raw_hist.size() > SYNC + 1) void'(raw_hist.pop_front());
      s_hist.push_back(s_now);
      if (s_hist.size() > DEB) void'(s_hist.pop_front());
      new_out = out_m;
      for (int i = 0; i < W; i++) begin
         all_diff = (s_hist.size() == DEB);
         foreach (s_hist[j]) if (s_hist[j][i] == out_m[i]) all_diff = 1'b0;
         if (all_diff) new_out[i] = ~out_m[i];
      end
      rs = new_out & ~out_m;
`ifdef SW_DEBOUNCE_STICKY_EN
      sticky_m = (sticky_m & ~clr_v) | rs;
`else
      sticky_m = '0;
`endif
      e.sw_out = new_out;
      e.rise   = rs;
      e.fall   = ~new_out & out_m;
      e.busy   = |(s_now ^ new_out);
      e.sticky = sticky_m;
      out_m    = new_out;
      return e;
   endfunction

   task automatic step(input logic rst_v, input logic [W-1:0] raw_v, input logic [W-1:0] clr_v);
      RST    = rst_v;
      sw_raw = raw_v;
      clr    = clr_v;
      exp_q.push_back(model_edge(rst_v, raw_v, clr_v));
      @(posedge CLK);
      #2;
   endtask

   task automatic hold(input int n, input logic [W-1:0] raw_v);
      repeat (n) step(1'b0, raw_v, '0);
   endtask

   // Monitor: the DUT presents a new output set on every edge.
   initial begin
      exp_t e, a;
      forever begin
         @(posedge CLK);
         #1;
         edge_n++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {sw_out, rise, fall, busy, sticky};
            tests++;
            if (a !== e) begin
               failed++;
               $display("FAIL edge%0d out/rise/fall/busy/sticky got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                        edge_n, a.sw_out, a.rise, a.fall, a.busy, a.sticky,
                        e.sw_out, e.rise, e.fall, e.busy, e.sticky);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] raw_r, clr_r;
      logic         rst_r;
      model_reset();
      RST = 1'b1; sw_raw = '1; clr = '0;

      repeat (3) step(1'b1, 4'b1111, '0);
      hold(6, 4'b0000);
      hold(8, 4'b0001);                                   // rise on bit 0
      repeat (2) begin
         hold(3, 4'b0011);                                // bounce on bit 1
         hold(3, 4'b0001);
      end
      hold(6, 4'b0001);
      hold(8, 4'b0000);                                   // release bit 0
      hold(4, 4'b0100);
      step(1'b1, 4'b0100, '0);                            // reset with a count in flight
      hold(8, 4'b0100);
      hold(8, 4'b1000);                                   // rise on bit 3
      step(1'b0, 4'b1000, 4'b1000);
      hold(2, 4'b1000);
      hold(8, 4'b0000);
      hold(5, 4'b1000);
      step(1'b0, 4'b1000, 4'b1000);                       // clear on the same edge as a rise
      hold(3, 4'b1000);

      raw_r = 4'b0000;
      for (int n = 0; n < 2500; n++) begin
         for (int i = 0; i < W; i++) begin
            if ($urandom_range(7, 0) == 0) raw_r[i] = ~raw_r[i];
            clr_r[i] = ($urandom_range(3, 0) == 0);
         end
         rst_r = ($urandom_range(299, 0) == 0);
         step(rst_r, raw_r, clr_r);
      end

      repeat (3) @(posedge CLK);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL drain pending got %0d want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
